// File: rtl/minimal_bus_pkg.sv
// Shared types and helpers for the minimal memory interface initiator and its responder model.
package minimal_bus_pkg;

    typedef enum logic [2:0] {IDLE, WGET, REQ, RSND, FIN} state_e;

    localparam int unsigned SZ8  = 8;
    localparam int unsigned SZ16 = 16;

    // Byte stride of one element; any size other than 8 bits moves as a 16-bit access.
    function automatic int unsigned size_to_bytes(input int unsigned size_bits);
        return (size_bits == SZ8) ? 32'd1 : 32'd2;
    endfunction

endpackage

// File: rtl/mbi_timeout_counter.sv
// Cycle counter bounding how long one memory request may wait for DataRdy.
module mbi_timeout_counter #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clock,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned      CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] TOP   = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != TOP)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // A count of TIMEOUT-1 means the request is in its last permitted cycle.
    assign expired_o = enable_i && (count_q == LAST);

endmodule

// File: rtl/minimal_bus_initiator.sv
// Burst master for the Bambu minimal memory interface: one oe/we access per element,
// read data out and write data in through valid/ready streams.
module minimal_bus_initiator #(
    parameter int unsigned ADDR_W  = 9,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned SIZE_W  = 5,
    parameter int unsigned LEN_W   = 8,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [SIZE_W-1:0] cmd_size,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              done,
    output logic              err,
    output logic              Mout_oe_ram,
    output logic              Mout_we_ram,
    output logic [ADDR_W-1:0] Mout_addr_ram,
    output logic [DATA_W-1:0] Mout_Wdata_ram,
    output logic [SIZE_W-1:0] Mout_data_ram_size,
    input  logic [DATA_W-1:0] M_Rdata_ram,
    input  logic              M_DataRdy
);

    import minimal_bus_pkg::*;

    state_e            state_q, state_d;
    logic              started_q;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [SIZE_W-1:0] size_q, size_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              expired;
    logic [DATA_W-1:0] rmask;
    logic [ADDR_W-1:0] addr_step;

    mbi_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clock     (clock),
        .reset     (reset),
        .clear_i   (state_q != REQ),
        .enable_i  (state_q == REQ),
        .expired_o (expired)
    );

    assign rmask     = (size_q == SIZE_W'(SZ8)) ? DATA_W'(8'hFF) : {DATA_W{1'b1}};
    assign addr_step = ADDR_W'(size_to_bytes(32'(size_q)));

    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        addr_d      = addr_q;
        len_d       = len_q;
        size_d      = size_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        cmd_ready   = 1'b0;
        wr_ready    = 1'b0;
        rd_valid    = 1'b0;
        done        = 1'b0;
        Mout_oe_ram = 1'b0;
        Mout_we_ram = 1'b0;
        case (state_q)
            IDLE: begin
                // started_q keeps cmd_ready low until the first edge after reset release.
                cmd_ready = started_q;
                if (cmd_valid && started_q) begin
                    write_d = cmd_write;
                    addr_d  = cmd_addr;
                    len_d   = cmd_len;
                    size_d  = (cmd_size == SIZE_W'(SZ8)) ? SIZE_W'(SZ8) : SIZE_W'(SZ16);
                    err_d   = 1'b0;
                    if (cmd_len == '0) begin
                        state_d = FIN;
                    end else if (cmd_write) begin
                        state_d = WGET;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            WGET: begin
                wr_ready = 1'b1;
                if (wr_valid) begin
                    wdata_d = wr_data;
                    state_d = REQ;
                end
            end
            REQ: begin
                Mout_oe_ram = !write_q;
                Mout_we_ram = write_q;
                if (M_DataRdy) begin
                    addr_d = addr_q + addr_step;
                    len_d  = len_q - LEN_W'(1);
                    if (!write_q) begin
                        rdata_d = M_Rdata_ram & rmask;
                        state_d = RSND;
                    end else if (len_q == LEN_W'(1)) begin
                        state_d = FIN;
                    end else begin
                        state_d = WGET;
                    end
                end else if (expired) begin
                    err_d   = 1'b1;
                    state_d = FIN;
                end
            end
            RSND: begin
                rd_valid = 1'b1;
                if (rd_ready) begin
                    state_d = (len_q != '0) ? REQ : FIN;
                end
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            started_q <= 1'b0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            started_q <= 1'b1;
            write_q   <= write_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            size_q    <= size_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    assign rd_data            = rdata_q;
    assign err                = err_q;
    assign Mout_addr_ram      = addr_q;
    assign Mout_Wdata_ram     = wdata_q;
    assign Mout_data_ram_size = size_q;

endmodule

// File: tb/tb_minimal_bus_initiator.sv
// Directed self-checking bench for minimal_bus_initiator with a behavioural memory responder.
module tb_minimal_bus_initiator;

    logic        clock;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [8:0]  cmd_addr;
    logic [7:0]  cmd_len;
    logic [4:0]  cmd_size;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [15:0] rd_data;
    logic        done;
    logic        err;
    logic        Mout_oe_ram;
    logic        Mout_we_ram;
    logic [8:0]  Mout_addr_ram;
    logic [15:0] Mout_Wdata_ram;
    logic [4:0]  Mout_data_ram_size;
    logic [15:0] M_Rdata_ram;
    logic        M_DataRdy;

    int          assertCount = 0;
    int          failCount   = 0;

    logic [7:0]  mem [0:511];
    int          respDelay   = 1;
    bit          noResp      = 0;
    int          busyCnt     = 0;
    bit          prevReq     = 0;
    int          reqStarts   = 0;
    int          oeStarts    = 0;
    int          weStarts    = 0;
    int          oeCycles    = 0;
    int          doneCount   = 0;
    logic [8:0]  addrLog [$];
    logic [15:0] rdLog [$];

    minimal_bus_initiator #(
        .ADDR_W  (9),
        .DATA_W  (16),
        .SIZE_W  (5),
        .LEN_W   (8),
        .TIMEOUT (64)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .cmd_write          (cmd_write),
        .cmd_addr           (cmd_addr),
        .cmd_len            (cmd_len),
        .cmd_size           (cmd_size),
        .wr_valid           (wr_valid),
        .wr_ready           (wr_ready),
        .wr_data            (wr_data),
        .rd_valid           (rd_valid),
        .rd_ready           (rd_ready),
        .rd_data            (rd_data),
        .done               (done),
        .err                (err),
        .Mout_oe_ram        (Mout_oe_ram),
        .Mout_we_ram        (Mout_we_ram),
        .Mout_addr_ram      (Mout_addr_ram),
        .Mout_Wdata_ram     (Mout_Wdata_ram),
        .Mout_data_ram_size (Mout_data_ram_size),
        .M_Rdata_ram        (M_Rdata_ram),
        .M_DataRdy          (M_DataRdy)
    );

    // Free-running 10-time-unit clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Responder: answers the respDelay-th cycle of each request. Byte reads return 0xA5 in
    // the upper byte so that the initiator's masking is exercised.
    initial begin
        logic [8:0] a;
        M_DataRdy   = 1'b0;
        M_Rdata_ram = 16'h0000;
        forever begin
            @(negedge clock);
            if (Mout_oe_ram || Mout_we_ram) begin
                if (!prevReq) begin
                    reqStarts++;
                    if (Mout_we_ram) weStarts++;
                    else             oeStarts++;
                end
                if (Mout_oe_ram) oeCycles++;
                busyCnt++;
                prevReq = 1'b1;
                if (!noResp && busyCnt == respDelay) begin
                    a = Mout_addr_ram;
                    addrLog.push_back(a);
                    M_DataRdy = 1'b1;
                    if (Mout_we_ram) begin
                        mem[a] = Mout_Wdata_ram[7:0];
                        if (Mout_data_ram_size != 5'd8) mem[a + 9'd1] = Mout_Wdata_ram[15:8];
                    end else if (Mout_data_ram_size == 5'd8) begin
                        M_Rdata_ram = {8'hA5, mem[a]};
                    end else begin
                        M_Rdata_ram = {mem[a + 9'd1], mem[a]};
                    end
                end else begin
                    M_DataRdy = 1'b0;
                end
            end else begin
                busyCnt   = 0;
                prevReq   = 1'b0;
                M_DataRdy = 1'b0;
            end
        end
    end

    // Stream monitor: samples just after the falling edge, i.e. the values the next rising edge sees.
    initial begin
        forever begin
            @(negedge clock);
            #1;
            if (rd_valid && rd_ready) rdLog.push_back(rd_data);
            if (done) doneCount++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Presents one command from a falling edge and returns at the falling edge after acceptance.
    task automatic applyStimulus(input logic w, input logic [8:0] a, input logic [7:0] len, input logic [4:0] sz);
        int n;
        n         = 0;
        cmd_write = w;
        cmd_addr  = a;
        cmd_len   = len;
        cmd_size  = sz;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        checkOutput("cmd accepted", 32'(cmd_ready), 32'd1);
        @(posedge clock);
        @(negedge clock);
        cmd_valid = 1'b0;
    endtask

    task automatic feedWrite(input logic [15:0] data);
        int n;
        n        = 0;
        wr_data  = data;
        wr_valid = 1'b1;
        while (!wr_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        checkOutput("wr_ready seen", 32'(wr_ready), 32'd1);
        @(posedge clock);
        @(negedge clock);
        wr_valid = 1'b0;
    endtask

    task automatic waitDone(input int budget);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clock);
            n++;
        end
        checkOutput("done seen", 32'(done), 32'd1);
        repeat (2) @(negedge clock);
    endtask

    task automatic clearLogs();
        addrLog.delete();
        rdLog.delete();
        reqStarts = 0;
        oeStarts  = 0;
        weStarts  = 0;
        oeCycles  = 0;
        doneCount = 0;
    endtask

    initial begin
        logic [15:0] expRd [4];
        int          n;
        bit          found;

        expRd = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        reset     = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        cmd_size  = '0;
        wr_valid  = 1'b0;
        wr_data   = '0;
        rd_ready  = 1'b0;

        $display("[TB] reset state");
        repeat (2) @(negedge clock);
        checkOutput("reset cmd_ready", 32'(cmd_ready), 32'd0);
        checkOutput("reset oe", 32'(Mout_oe_ram), 32'd0);
        checkOutput("reset we", 32'(Mout_we_ram), 32'd0);
        checkOutput("reset addr", 32'(Mout_addr_ram), 32'd0);
        checkOutput("reset size", 32'(Mout_data_ram_size), 32'd0);
        checkOutput("reset rd_data", 32'(rd_data), 32'd0);
        checkOutput("reset err", 32'(err), 32'd0);
        reset = 1'b1;
        checkOutput("cmd_ready before first edge", 32'(cmd_ready), 32'd0);
        @(negedge clock);
        checkOutput("cmd_ready after release", 32'(cmd_ready), 32'd1);

        $display("[TB] read burst, byte size, delay 2");
        mem[9'h010] = 8'h11;
        mem[9'h011] = 8'h22;
        mem[9'h012] = 8'h33;
        mem[9'h013] = 8'h44;
        respDelay = 2;
        rd_ready  = 1'b1;
        clearLogs();
        applyStimulus(1'b0, 9'h010, 8'd4, 5'd8);
        waitDone(200);
        checkOutput("read count", 32'(rdLog.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("read data %0d", i), 32'(rdLog[i]), 32'(expRd[i]));
            checkOutput($sformatf("read addr %0d", i), 32'(addrLog[i]), 32'h010 + 32'(i));
        end
        checkOutput("read done count", 32'(doneCount), 32'd1);
        checkOutput("read err", 32'(err), 32'd0);

        $display("[TB] write burst with address wrap");
        respDelay = 1;
        clearLogs();
        applyStimulus(1'b1, 9'h1FE, 8'd2, 5'd16);
        feedWrite(16'hBEEF);
        feedWrite(16'hCAFE);
        waitDone(100);
        checkOutput("write addr 0", 32'(addrLog[0]), 32'h1FE);
        checkOutput("write addr 1", 32'(addrLog[1]), 32'h000);
        checkOutput("write we starts", 32'(weStarts), 32'd2);
        checkOutput("write oe starts", 32'(oeStarts), 32'd0);
        checkOutput("mem 1FE", 32'(mem[9'h1FE]), 32'hEF);
        checkOutput("mem 1FF", 32'(mem[9'h1FF]), 32'hBE);
        checkOutput("mem 000", 32'(mem[9'h000]), 32'hFE);
        checkOutput("mem 001", 32'(mem[9'h001]), 32'hCA);
        checkOutput("write done count", 32'(doneCount), 32'd1);

        $display("[TB] read stall on rd_ready");
        mem[9'h020] = 8'h5A;
        mem[9'h021] = 8'h6B;
        rd_ready    = 1'b0;
        clearLogs();
        applyStimulus(1'b0, 9'h020, 8'd2, 5'd8);
        n = 0;
        while (!rd_valid && n < 50) begin
            @(negedge clock);
            n++;
        end
        checkOutput("stall rd_valid", 32'(rd_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            checkOutput("stall rd_data held", 32'(rd_data), 32'h005A);
        end
        checkOutput("stall single request", 32'(reqStarts), 32'd1);
        rd_ready = 1'b1;
        waitDone(100);
        checkOutput("stall total reads", 32'(oeStarts), 32'd2);
        checkOutput("stall read 0", 32'(rdLog[0]), 32'h005A);
        checkOutput("stall read 1", 32'(rdLog[1]), 32'h006B);

        $display("[TB] timeout");
        noResp = 1'b1;
        clearLogs();
        applyStimulus(1'b0, 9'h030, 8'd1, 5'd8);
        waitDone(200);
        checkOutput("timeout oe cycles", 32'(oeCycles), 32'd64);
        checkOutput("timeout requests", 32'(reqStarts), 32'd1);
        checkOutput("timeout err set", 32'(err), 32'd1);
        checkOutput("timeout done count", 32'(doneCount), 32'd1);
        noResp = 1'b0;

        // The zero-length command also shows that a new command clears err.
        $display("[TB] zero length");
        clearLogs();
        applyStimulus(1'b0, 9'h040, 8'd0, 5'd8);
        checkOutput("zero-len done", 32'(done), 32'd1);
        checkOutput("err cleared", 32'(err), 32'd0);
        @(negedge clock);
        checkOutput("zero-len done drop", 32'(done), 32'd0);
        checkOutput("zero-len cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("zero-len no access", 32'(reqStarts), 32'd0);

        $display("[TB] reset mid-burst");
        respDelay = 3;
        rd_ready  = 1'b1;
        clearLogs();
        applyStimulus(1'b0, 9'h050, 8'd3, 5'd8);
        found = 1'b0;
        n     = 0;
        while (!found && n < 200) begin
            @(negedge clock);
            #2;
            n++;
            if (reqStarts == 2 && Mout_oe_ram) found = 1'b1;
        end
        checkOutput("second access oe", 32'(Mout_oe_ram), 32'd1);
        reset = 1'b0;
        #1;
        checkOutput("mid reset oe", 32'(Mout_oe_ram), 32'd0);
        checkOutput("mid reset we", 32'(Mout_we_ram), 32'd0);
        checkOutput("mid reset rd_valid", 32'(rd_valid), 32'd0);
        checkOutput("mid reset done", 32'(done), 32'd0);
        checkOutput("mid reset cmd_ready", 32'(cmd_ready), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("post reset cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("no done after abort", 32'(doneCount), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
